// File: rtl/convolution_loop_ctrl.sv
// Loop sequencer for a 1-D convolution MAC datapath.
// It walks output index i and the clipped inner index j, and drives addresses and strobes.
module convolution_loop_ctrl #(
   parameter int DATAWIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [DATAWIDTH-1:0] size_x_i,
   input  logic [DATAWIDTH-1:0] size_h_i,
   output logic [DATAWIDTH-1:0] addr_x_o,
   output logic [DATAWIDTH-1:0] addr_h_o,
   output logic [DATAWIDTH:0]   addr_y_o,
   output logic                 acc_clr_o,
   output logic                 acc_en_o,
   output logic                 y_we_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_MAC,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [DATAWIDTH:0]   ONE_W = (DATAWIDTH+1)'(1);
   localparam logic [DATAWIDTH:0]   TWO_W = (DATAWIDTH+1)'(2);
   localparam logic [DATAWIDTH-1:0] ONE_D = DATAWIDTH'(1);

   state_t               state, state_next;
   logic [DATAWIDTH:0]   i_cnt, i_next;
   logic [DATAWIDTH-1:0] j_cnt, j_next;
   logic [DATAWIDTH-1:0] n_len, n_next;
   logic [DATAWIDTH-1:0] m_len, m_next;

   logic [DATAWIDTH:0]   n_ext, m_ext, i_last;
   logic [DATAWIDTH-1:0] j_start, j_end;

   assign n_ext  = {1'b0, n_len};
   assign m_ext  = {1'b0, m_len};
   assign i_last = n_ext + m_ext - TWO_W;

   // The overlap window bounds fit in DATAWIDTH bits, so the wide
   // differences are only needed for the comparisons.
   assign j_start = (i_cnt >= m_ext) ? (i_cnt[DATAWIDTH-1:0] - m_len + ONE_D) : '0;
   assign j_end   = (i_cnt <  n_ext) ? i_cnt[DATAWIDTH-1:0] : (n_len - ONE_D);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         i_cnt <= '0;
         j_cnt <= '0;
         n_len <= '0;
         m_len <= '0;
      end else begin
         state <= state_next;
         i_cnt <= i_next;
         j_cnt <= j_next;
         n_len <= n_next;
         m_len <= m_next;
      end
   end

   // NOTE: every signal written here gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      i_next     = i_cnt;
      j_next     = j_cnt;
      n_next     = n_len;
      m_next     = m_len;
      addr_x_o   = '0;
      addr_h_o   = '0;
      addr_y_o   = '0;
      acc_clr_o  = 1'b0;
      acc_en_o   = 1'b0;
      y_we_o     = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start_i) begin
               n_next = size_x_i;
               m_next = size_h_i;
               if (size_x_i == '0 || size_h_i == '0) begin
                  state_next = S_DONE;
               end else begin
                  i_next     = '0;
                  state_next = S_INIT;
               end
            end
         end
         S_INIT: begin
            busy_o     = 1'b1;
            acc_clr_o  = 1'b1;
            j_next     = j_start;
            state_next = S_MAC;
         end
         S_MAC: begin
            busy_o   = 1'b1;
            acc_en_o = 1'b1;
            addr_x_o = j_cnt;
            addr_h_o = i_cnt[DATAWIDTH-1:0] - j_cnt;
            if (j_cnt == j_end) begin
               state_next = S_WRITE;
            end else begin
               j_next = j_cnt + ONE_D;
            end
         end
         S_WRITE: begin
            busy_o   = 1'b1;
            y_we_o   = 1'b1;
            addr_y_o = i_cnt;
            if (i_cnt == i_last) begin
               state_next = S_DONE;
            end else begin
               i_next     = i_cnt + ONE_W;
               state_next = S_INIT;
            end
         end
         S_DONE: begin
            done_o     = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule
